deser_word_framer: RTL and testbench

- Downstream consumer of the enabled D flop's registered output stream. Collects WIDTH serial bits qualified by a valid strobe into a parallel word.
- Presents each completed word on a valid/ready output port backed by one holding register, and reports words dropped on overflow.
- Sits between the single-bit capture flop and any word-level consumer, such as a register file or FIFO.

---
 rtl/deser_word_framer.sv | 176 +++++++++++++++++
 tb/tb_deser_word_framer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_word_framer.sv
// deser_word_framer: collects WIDTH valid-qualified serial bits into a word and
// presents it on a valid/ready port backed by a single holding register.
// Optional build macro: DESER_PARITY_EN appends one even-parity bit per frame
// and reports the check result on out_perr (tied to 0 when undefined).
module deser_word_framer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(WIDTH);

`ifdef DESER_PARITY_EN
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    COLLECT = 1'b0
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d, sr_ins;
  logic [IDX_W-1:0]   bit_pos;
  logic               last_bit;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   done_word_q, done_word_d;
`ifdef DESER_PARITY_EN
  logic               done_perr_q, done_perr_d;
`endif
  logic               pop_c, load_c, drop_c;

  // Slot for the incoming bit: counter order, mirrored when MSB_FIRST is set
  always_comb begin
    bit_pos = IDX_W'(cnt_q);
    if (MSB_FIRST != 0) begin
      bit_pos = IDX_W'(WIDTH - 1) - IDX_W'(cnt_q);
    end
    sr_ins          = sr_q;
    sr_ins[bit_pos] = bit_in;
    last_bit        = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and frame datapath; frame_clr overrides any accepted bit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    done_d      = 1'b0;
    done_word_d = done_word_q;
`ifdef DESER_PARITY_EN
    done_perr_d = done_perr_q;
`endif
    if (frame_clr) begin
      state_d = COLLECT;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (bit_vld) begin
      unique case (state_q)
        COLLECT: begin
          sr_d = sr_ins;
          if (last_bit) begin
            cnt_d = '0;
`ifdef DESER_PARITY_EN
            state_d = PARITY;
`else
            done_d      = 1'b1;
            done_word_d = sr_ins;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef DESER_PARITY_EN
        PARITY: begin
          state_d     = COLLECT;
          done_d      = 1'b1;
          done_word_d = sr_q;
          done_perr_d = ^{sr_q, bit_in};
        end
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame registers: counter, shift register, one-cycle completion stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      done_q      <= 1'b0;
      done_word_q <= '0;
`ifdef DESER_PARITY_EN
      done_perr_q <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      done_q      <= done_d;
      done_word_q <= done_word_d;
`ifdef DESER_PARITY_EN
      done_perr_q <= done_perr_d;
`endif
    end
  end

  // Holding-register decisions for a completed word
  always_comb begin
    pop_c  = out_valid && out_ready;
    load_c = done_q && (!out_valid || out_ready);
    drop_c = done_q && out_valid && !out_ready;
  end

  // Holding register and valid flag; pop and load together keep valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_data  <= done_word_q;
      out_valid <= 1'b1;
    end else if (pop_c) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  // Parity flag travels with the held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_perr <= 1'b0;
    end else if (load_c) begin
      out_perr <= done_perr_q;
    end
  end
`else
  assign out_perr = 1'b0;
`endif

  // Sticky overflow; a same-cycle drop beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser_word_framer.sv
// Bench for deser_word_framer: two instances (LSB-first and MSB-first) share
// one stimulus stream and are compared every cycle against a bit-position
// model of framing, holding register and overflow, plus literal spot checks.
module tb_deser_word_framer;

  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = W + (PAR ? 1 : 0);

  logic         clk, rst_n;
  logic         bit_in, bit_vld, frame_clr, out_ready, ovf_clr;
  logic [W-1:0] out_data0, out_data1;
  logic         out_valid0, out_valid1, out_perr0, out_perr1, overflow0, overflow1;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  deser_word_framer #(.WIDTH(W), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .frame_clr(frame_clr), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_perr(out_perr0), .overflow(overflow0),
    .ovf_clr(ovf_clr)
  );

  deser_word_framer #(.WIDTH(W), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .frame_clr(frame_clr), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_perr(out_perr1), .overflow(overflow1),
    .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = LSB-first, 1 = MSB-first
  logic [W-1:0] md [2];
  logic [W-1:0] acc [2];
  logic [W-1:0] pw [2];
  bit           mv [2];
  bit           mp [2];
  bit           movf [2];
  bit           pend [2];
  bit           pp [2];
  int           nb [2];
  bit           drop_m;
  int           pos_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        md[m] = '0; acc[m] = '0; pw[m] = '0; mv[m] = 1'b0; mp[m] = 1'b0;
        movf[m] = 1'b0; pend[m] = 1'b0; pp[m] = 1'b0; nb[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        drop_m = pend[m] && mv[m] && !out_ready;
        if (pend[m] && (!mv[m] || out_ready)) begin
          md[m] = pw[m];
          mp[m] = pp[m];
          mv[m] = 1'b1;
        end else if (mv[m] && out_ready) begin
          mv[m] = 1'b0;
        end
        if (drop_m) movf[m] = 1'b1;
        else if (ovf_clr) movf[m] = 1'b0;
        pend[m] = 1'b0;
        if (frame_clr) begin
          nb[m]  = 0;
          acc[m] = '0;
        end else if (bit_vld) begin
          if (nb[m] < W) begin
            pos_m = (m == 1) ? (W - 1 - nb[m]) : nb[m];
            acc[m][pos_m] = bit_in;
          end
          nb[m] = nb[m] + 1;
          if (nb[m] == FL) begin
            pend[m] = 1'b1;
            pw[m]   = acc[m];
            pp[m]   = PAR ? ((^acc[m]) ^ bit_in) : 1'b0;
            nb[m]   = 0;
            acc[m]  = '0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data0",  32'(out_data0),  32'(md[0]));
      chk("valid0", 32'(out_valid0), 32'(mv[0]));
      chk("perr0",  32'(out_perr0),  32'(mp[0]));
      chk("ovf0",   32'(overflow0),  32'(movf[0]));
      chk("data1",  32'(out_data1),  32'(md[1]));
      chk("valid1", 32'(out_valid1), 32'(mv[1]));
      chk("perr1",  32'(out_perr1),  32'(mp[1]));
      chk("ovf1",   32'(overflow1),  32'(movf[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Bit i of w is sent i-th; optional gap cycles carry a junk bit_in
  task automatic send_word(input logic [W-1:0] w, input logic par, input bit gaps);
    for (int i = 0; i < FL; i++) begin
      bit_in  = (i < W) ? w[i] : par;
      bit_vld = 1'b1;
      cyc();
      bit_vld = 1'b0;
      bit_in  = 1'b0;
      if (gaps && i != FL - 1) begin
        bit_in = 1'b1;
        cyc();
        bit_in = 1'b0;
      end
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bit_in  = 1'b1;
      bit_vld = 1'b1;
      cyc();
    end
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; frame_clr = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    cyc(); cyc();
    #3;
    chk("rst_valid", 32'(out_valid0), 32'd0);
    chk("rst_data",  32'(out_data0),  32'd0);
    chk("rst_ovf",   32'(overflow0),  32'd0);
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Basic frame, both bit orders
    send_word(8'h4D, 1'b0, 1'b0);
    #3;
    chk("lat_valid", 32'(out_valid0), 32'd0);
    cyc();
    #3;
    chk("basic_lsb", 32'(out_data0), 32'h4D);
    chk("basic_msb", 32'(out_data1), 32'hB2);
    chk("basic_valid", 32'(out_valid0), 32'd1);
    chk("basic_perr", 32'(out_perr0), 32'd0);
    cyc();
    #3;
    chk("basic_pop", 32'(out_valid0), 32'd0);

    // Gapped frame
    send_word(8'h4D, 1'b0, 1'b1);
    cyc();
    #3;
    chk("gap_lsb", 32'(out_data0), 32'h4D);
    cyc();

`ifdef DESER_PARITY_EN
    send_word(8'h4D, 1'b1, 1'b0);
    cyc();
    #3;
    chk("perr_bad", 32'(out_perr0), 32'd1);
    cyc();
`endif

    // Backpressure and overflow
    out_ready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0);
    cyc();
    send_word(8'h3C, 1'b0, 1'b0);
    cyc();
    #3;
    chk("bp_data", 32'(out_data0), 32'hA5);
    chk("bp_ovf",  32'(overflow0), 32'd1);
    cyc();
    out_ready = 1'b1;
    cyc();
    #3;
    chk("bp_pop", 32'(out_valid0), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow0), 32'd1);
    cyc();
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    #3;
    chk("ovf_clr", 32'(overflow0), 32'd0);

    // Pop and load in the same cycle
    cyc();
    out_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b0);
    cyc();
    send_word(8'h22, 1'b0, 1'b0);
    out_ready = 1'b1;
    cyc();
    #3;
    chk("pl_valid", 32'(out_valid0), 32'd1);
    chk("pl_data",  32'(out_data0),  32'h22);
    chk("pl_ovf",   32'(overflow0),  32'd0);
    cyc();

    // frame_clr mid-frame
    send_bits(5);
    frame_clr = 1'b1;
    bit_vld   = 1'b1;
    bit_in    = 1'b1;
    cyc();
    frame_clr = 1'b0;
    bit_vld   = 1'b0;
    bit_in    = 1'b0;
    send_word(8'hFF, 1'b0, 1'b0);
    cyc();
    #3;
    chk("fclr_data", 32'(out_data0), 32'hFF);
    chk("fclr_valid", 32'(out_valid0), 32'd1);
    cyc();

    // Asynchronous reset mid-frame
    send_bits(3);
    rst_n = 1'b0;
    #1;
    chk("arst_data",  32'(out_data0),  32'd0);
    chk("arst_valid", 32'(out_valid0), 32'd0);
    chk("arst_ovf",   32'(overflow0),  32'd0);
    chk("arst_perr",  32'(out_perr0),  32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    send_word(8'h4D, 1'b0, 1'b0);
    cyc();
    #3;
    chk("post_rst", 32'(out_data0), 32'h4D);
    cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit_vld   = ($urandom_range(0, 9) < 7);
      bit_in    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      frame_clr = ($urandom_range(0, 49) == 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      cyc();
    end
    bit_vld = 1'b0; frame_clr = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
